alu_ctrl_issue: RTL and testbench
=================================

Name: alu_ctrl_issue

Overview:
- Control-side counterpart of the datapath ALU: decodes ALUOp plus the RISC-V funct7/funct3 fields into the 3-bit ALUCtrl code the ALU consumes.
- Issues one code per accepted request through a registered output stage, with a valid/ready handshake.
- Holds MUL issues stable for a programmable number of cycles so the ALU multiply path can settle.
- Sits between the main control/ID stage and the EX-stage ALU.

Parameters:
- MUL_CYCLES, 4, number of cycles ALUCtrl_o is held at MUL before completion (legal range 1..15).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- valid_i  input  1  request valid from the control stage.
- ready_o  output  1  block can accept a request this cycle.
- ALUOp_i  input  2  00 load/store, 01 branch, 10 R-type, 11 I-type arithmetic.
- funct7_i  input  7  instruction bits [31:25].
- funct3_i  input  3  instruction bits [14:12].
- ALUCtrl_o  output  3  code to the ALU (000 AND, 001 OR, 010 ADD, 100 MUL, 110 SUB, 011 pass-through).
- ctrl_valid_o  output  1  ALUCtrl_o is a completed issue this cycle.
- illegal_o  output  1  the issue completing this cycle was undecodable.
- busy_o  output  1  multi-cycle MUL in progress.

Behaviour:
- Reset (rst_i low, asynchronous):
  - State goes to IDLE and the counter to 0.
  - ALUCtrl_o = 3'b011, ctrl_valid_o = 0, illegal_o = 0, busy_o = 0, ready_o = 1.
- Accept: on the rising edge where valid_i && ready_o. A valid_i with ready_o low is ignored; the requester holds it.
- Decode of the accepted request:
  - ALUOp 00 -> 010.
  - ALUOp 01 -> 110.
  - ALUOp 11 with funct3 000 -> 010; any other funct3 is illegal.
  - ALUOp 10 with funct7 0000000:
    - funct3 111 -> 000.
    - funct3 110 -> 001.
    - funct3 000 -> 010.
  - ALUOp 10 with funct7 0100000 and funct3 000 -> 110.
  - ALUOp 10 with funct7 0000001 and funct3 000 -> 100.
  - Every other combination is illegal: code 011, illegal_o = 1.
- FSM states: IDLE, ISSUE, MUL_WAIT.
  - IDLE/ISSUE, no accept: next state IDLE. ctrl_valid_o = 0 and illegal_o = 0 next cycle. ALUCtrl_o holds its last value.
  - IDLE/ISSUE, accept of a non-MUL or illegal request: next state ISSUE. The code is registered to ALUCtrl_o and ctrl_valid_o = 1 for exactly one cycle (latency 1). ready_o stays 1, so throughput is 1 per cycle back-to-back.
  - Accept of a MUL with MUL_CYCLES = 1: treated identically to a non-MUL accept.
  - Accept of a MUL with MUL_CYCLES > 1:
    - Next state MUL_WAIT, ALUCtrl_o = 100, counter = MUL_CYCLES-1.
    - busy_o = 1, ready_o = 0, ctrl_valid_o = 0.
  - MUL_WAIT: the counter decrements each cycle and ALUCtrl_o is held at 100.
    - When the counter reaches 0, that cycle has ctrl_valid_o = 1, busy_o = 0 and ready_o = 1.
    - A request accepted on that edge proceeds per the IDLE rules, with no bubble.
    - Total MUL occupancy is exactly MUL_CYCLES cycles of ALUCtrl_o = 100.
- ready_o = !(state == MUL_WAIT && counter != 0). It is combinational from state only and never from valid_i.
- illegal_o is registered alongside ctrl_valid_o and is only ever 1 when ctrl_valid_o = 1.
- Reset during MUL_WAIT aborts immediately to reset values; no ctrl_valid_o is produced for the aborted MUL.
- X on funct inputs while valid_i = 0 must not change any output.

Test Plan:
- Reset release -> ALUCtrl_o = 011, ctrl_valid_o = 0, busy_o = 0, ready_o = 1; hold idle 5 cycles with valid_i = 0 -> no change.
- Back-to-back accepts on consecutive edges: ALUOp 00, then 01, then 10/0000000/111, then 10/0000000/110, then 11/000 -> ALUCtrl_o = 010, 110, 000, 001, 010 on the following consecutive cycles, ctrl_valid_o high all 5 cycles, illegal_o = 0.
- MUL_CYCLES = 4, accept ALUOp 10/0000001/000 ->
  - ALUCtrl_o = 100 for 4 cycles.
  - busy_o = 1 and ready_o = 0 for the first 3.
  - ctrl_valid_o = 1 only on the 4th.
  - An ADD presented and accepted on that 4th cycle's edge appears as 010 the next cycle.
- During MUL_WAIT, toggle valid_i with an SUB request -> not accepted, no ctrl_valid_o, and SUB issues exactly once after ready_o rises.
- Illegal request ALUOp 10/0100000/111 -> ALUCtrl_o = 011, ctrl_valid_o = 1, illegal_o = 1 for one cycle.
- Assert rst_i low 2 cycles into a MUL -> outputs return to reset values asynchronously; after release a new ADD issues normally with no stale MUL completion.

Source files
------------

// File: rtl/alu_ctrl_issue_if.sv
// Request/issue bundle between the control stage and the ALU-control issue block.
// master = control/ID side, slave = alu_ctrl_issue.
interface alu_ctrl_issue_if;
  logic       valid_i;
  logic       ready_o;
  logic [1:0] ALUOp_i;
  logic [6:0] funct7_i;
  logic [2:0] funct3_i;
  logic [2:0] ALUCtrl_o;
  logic       ctrl_valid_o;
  logic       illegal_o;
  logic       busy_o;

  modport master (
    output valid_i, ALUOp_i, funct7_i, funct3_i,
    input  ready_o, ALUCtrl_o, ctrl_valid_o, illegal_o, busy_o
  );

  modport slave (
    input  valid_i, ALUOp_i, funct7_i, funct3_i,
    output ready_o, ALUCtrl_o, ctrl_valid_o, illegal_o, busy_o
  );
endinterface

// File: rtl/alu_ctrl_issue.sv
// Decodes ALUOp/funct7/funct3 into the 3-bit ALUCtrl code and issues it through a
// registered valid/ready stage; MUL issues are held for MUL_CYCLES cycles.
module alu_ctrl_issue #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  alu_ctrl_issue_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, MUL_WAIT} state_t;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_PASS = 3'b011;
  localparam logic [2:0] ALU_MUL  = 3'b100;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       illegal_q, illegal_d;
  logic       busy_q, busy_d;

  logic       ready;
  logic       accept;
  logic [2:0] dec_code;
  logic       dec_illegal;
  logic       dec_mul;

  assign ready  = !(state_q == MUL_WAIT && cnt_q != '0);
  assign accept = bus.valid_i && ready;

  always_comb begin
    dec_code    = ALU_PASS;
    dec_illegal = 1'b1;
    case (bus.ALUOp_i)
      2'b00: begin
        dec_code    = ALU_ADD;
        dec_illegal = 1'b0;
      end
      2'b01: begin
        dec_code    = ALU_SUB;
        dec_illegal = 1'b0;
      end
      2'b11: begin
        if (bus.funct3_i == 3'b000) begin
          dec_code    = ALU_ADD;
          dec_illegal = 1'b0;
        end
      end
      2'b10: begin
        if (bus.funct7_i == 7'b0000000) begin
          case (bus.funct3_i)
            3'b111:  begin dec_code = ALU_AND; dec_illegal = 1'b0; end
            3'b110:  begin dec_code = ALU_OR;  dec_illegal = 1'b0; end
            3'b000:  begin dec_code = ALU_ADD; dec_illegal = 1'b0; end
            default: ;
          endcase
        end else if (bus.funct7_i == 7'b0100000 && bus.funct3_i == 3'b000) begin
          dec_code    = ALU_SUB;
          dec_illegal = 1'b0;
        end else if (bus.funct7_i == 7'b0000001 && bus.funct3_i == 3'b000) begin
          dec_code    = ALU_MUL;
          dec_illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign dec_mul = !dec_illegal && dec_code == ALU_MUL;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    illegal_d = 1'b0;
    busy_d    = 1'b0;
    if (state_q == MUL_WAIT && cnt_q != '0) begin
      // Final countdown step lands on cnt 0, which is the completing MUL cycle.
      cnt_d   = cnt_q - 4'd1;
      code_d  = ALU_MUL;
      busy_d  = (cnt_q != 4'd1);
      valid_d = (cnt_q == 4'd1);
    end else if (accept) begin
      if (dec_mul && MUL_CYCLES > 1) begin
        state_d = MUL_WAIT;
        cnt_d   = MUL_LAST;
        code_d  = ALU_MUL;
        busy_d  = 1'b1;
      end else begin
        state_d   = ISSUE;
        code_d    = dec_code;
        valid_d   = 1'b1;
        illegal_d = dec_illegal;
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      code_q    <= ALU_PASS;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ready_o      = ready;
  assign bus.ALUCtrl_o    = code_q;
  assign bus.ctrl_valid_o = valid_q;
  assign bus.illegal_o    = illegal_q;
  assign bus.busy_o       = busy_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Scoreboard bench for alu_ctrl_issue: stimulus pushes expected issues, a negedge
// monitor pops and compares them whenever ctrl_valid_o is high.
module tb_alu_ctrl_issue;

  logic clk_i;
  logic rst_i;

  alu_ctrl_issue_if bus();

  alu_ctrl_issue #(.MUL_CYCLES(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] code;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk;
  int   n_pass;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: consumes expected issues in order.
  always @(negedge clk_i) begin
    if (rst_i) begin
      chk("illegal_gated", 32'(bus.illegal_o & ~bus.ctrl_valid_o), 32'd0);
      if (bus.ctrl_valid_o) begin
        chk("issue_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("issue_code", 32'(bus.ALUCtrl_o), 32'(e.code));
          chk("issue_illegal", 32'(bus.illegal_o), 32'(e.ill));
        end
      end
    end
  end

  // Present a request, wait for ready, push its expected issue, hold across the accept edge.
  task automatic send(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                      input logic [2:0] code, input logic ill);
    int n;
    bus.valid_i  = 1'b1;
    bus.ALUOp_i  = op;
    bus.funct7_i = f7;
    bus.funct3_i = f3;
    n = 0;
    while (!bus.ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("accept_wait", 32'(n >= 50), 32'd0);
    if (n < 50) exp_q.push_back('{code: code, ill: ill});
    @(posedge clk_i);
    #1;
    bus.valid_i  = 1'b0;
    bus.funct7_i = 'x;
    bus.funct3_i = 'x;
  endtask

  task automatic idle(input int n, input logic [2:0] held);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      chk("idle_code", 32'(bus.ALUCtrl_o), 32'(held));
      chk("idle_valid", 32'(bus.ctrl_valid_o), 32'd0);
      chk("idle_busy", 32'(bus.busy_o), 32'd0);
      chk("idle_ready", 32'(bus.ready_o), 32'd1);
    end
  endtask

  task automatic chk_mul_cycle(input logic busy, input logic ready, input logic cv);
    chk("mul_code", 32'(bus.ALUCtrl_o), 32'b100);
    chk("mul_busy", 32'(bus.busy_o), 32'(busy));
    chk("mul_ready", 32'(bus.ready_o), 32'(ready));
    chk("mul_valid", 32'(bus.ctrl_valid_o), 32'(cv));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_i        = 1'b1;
    bus.valid_i  = 1'b0;
    bus.ALUOp_i  = 2'b00;
    bus.funct7_i = '0;
    bus.funct3_i = '0;
    #1 rst_i = 1'b0;

    // Reset values
    repeat (2) @(negedge clk_i);
    chk("rst_code", 32'(bus.ALUCtrl_o), 32'b011);
    chk("rst_valid", 32'(bus.ctrl_valid_o), 32'd0);
    chk("rst_illegal", 32'(bus.illegal_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_ready", 32'(bus.ready_o), 32'd1);
    rst_i = 1'b1;
    bus.funct7_i = 'x;
    bus.funct3_i = 'x;
    idle(5, 3'b011);

    // Back-to-back decodes
    send(2'b00, 7'b0000000, 3'b000, 3'b010, 1'b0);
    send(2'b01, 7'b0000000, 3'b000, 3'b110, 1'b0);
    send(2'b10, 7'b0000000, 3'b111, 3'b000, 1'b0);
    send(2'b10, 7'b0000000, 3'b110, 3'b001, 1'b0);
    send(2'b11, 7'b1111111, 3'b000, 3'b010, 1'b0);
    @(negedge clk_i);
    idle(2, 3'b010);

    // MUL occupancy, then ADD accepted on the completing edge
    send(2'b10, 7'b0000001, 3'b000, 3'b100, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      chk_mul_cycle(1'b1, 1'b0, 1'b0);
    end
    @(negedge clk_i);
    chk_mul_cycle(1'b0, 1'b1, 1'b1);
    send(2'b00, 7'b0000000, 3'b000, 3'b010, 1'b0);
    @(negedge clk_i);
    chk("post_mul_add", 32'(bus.ALUCtrl_o), 32'b010);
    idle(2, 3'b010);

    // SUB toggled during MUL_WAIT must issue exactly once
    send(2'b10, 7'b0000001, 3'b000, 3'b100, 1'b0);
    bus.ALUOp_i  = 2'b10;
    bus.funct7_i = 7'b0100000;
    bus.funct3_i = 3'b000;
    bus.valid_i  = 1'b1;
    @(posedge clk_i); #1 bus.valid_i = 1'b0;
    @(posedge clk_i); #1 bus.valid_i = 1'b1;
    @(posedge clk_i); #1;
    send(2'b10, 7'b0100000, 3'b000, 3'b110, 1'b0);
    @(negedge clk_i);
    idle(2, 3'b110);

    // Illegal encodings, then a legal SUB
    send(2'b10, 7'b0100000, 3'b111, 3'b011, 1'b1);
    send(2'b11, 7'b0000000, 3'b001, 3'b011, 1'b1);
    send(2'b10, 7'b0100000, 3'b000, 3'b110, 1'b0);
    @(negedge clk_i);
    idle(2, 3'b110);

    // Reset two cycles into a MUL aborts it
    send(2'b10, 7'b0000001, 3'b000, 3'b100, 1'b0);
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_code", 32'(bus.ALUCtrl_o), 32'b011);
    chk("abort_valid", 32'(bus.ctrl_valid_o), 32'd0);
    chk("abort_illegal", 32'(bus.illegal_o), 32'd0);
    chk("abort_busy", 32'(bus.busy_o), 32'd0);
    chk("abort_ready", 32'(bus.ready_o), 32'd1);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    idle(5, 3'b011);
    send(2'b00, 7'b0000000, 3'b000, 3'b010, 1'b0);
    @(negedge clk_i);
    chk("post_abort_add", 32'(bus.ALUCtrl_o), 32'b010);
    idle(3, 3'b010);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
